// File: rtl/typed_arb_pkg.sv
// typed_arb_pkg: shared types and defaults for the typed round-robin arbiter
package typed_arb_pkg;
   typedef logic [2:0] three_t;
   localparam int NREQ_DEFAULT = 4;
   typedef enum logic {IDLE, RESP} arb_state_t;
endpackage

// File: rtl/typed_inv_stage.sv
// typed_inv_stage: registered bitwise inversion of the granted word plus its valid flag
import typed_arb_pkg::*;

module typed_inv_stage #(
   parameter type p_t = shortint
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic clear,
   input  p_t   din,
   output p_t   dout,
   output logic vld
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dout <= '0;
         vld  <= 1'b0;
      end else if (load) begin
         dout <= ~din;
         vld  <= 1'b1;
      end else if (clear) vld <= 1'b0;
endmodule

// File: rtl/typed_rr_arbiter.sv
// typed_rr_arbiter: round-robin arbiter returning the inverted word of the granted requester
import typed_arb_pkg::*;

module typed_rr_arbiter #(
   parameter type p_t  = shortint,
   parameter int  NREQ = NREQ_DEFAULT,
   parameter int  IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_valid,
   input  p_t              req_data [NREQ],
   output logic [NREQ-1:0] req_ready,
   output logic            out_valid,
   output p_t              out_data,
   output logic [IDW-1:0]  out_id,
   input  logic            out_ready,
   output logic            busy
);
   arb_state_t state, state_nxt;
   logic [IDW-1:0] rr_ptr, gnt, off;
   logic [IDW:0] sum;
   logic [NREQ-1:0] rot;
   logic found, slot_free, xfer;
   // rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins
   always_comb begin
      rot = NREQ'({req_valid, req_valid} >> rr_ptr);
      found = 1'b0;
      off = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (rot[i]) begin
            found = 1'b1;
            off = IDW'(i);
         end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      gnt = sum >= (IDW+1)'(NREQ) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
   end
   assign slot_free = state == IDLE || out_ready;
   assign xfer      = found && slot_free;
   assign req_ready = (rst_n && xfer) ? NREQ'(1) << gnt : '0;
   assign busy      = state == RESP;
   always_comb state_nxt = xfer ? RESP : (out_ready ? IDLE : state);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
         out_id <= '0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            rr_ptr <= gnt == IDW'(NREQ - 1) ? '0 : gnt + 1'b1;
            out_id <= gnt;
         end
      end
   typed_inv_stage #(.p_t(p_t)) u_inv (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (xfer),
      .clear (out_ready),
      .din   (req_data[gnt]),
      .dout  (out_data),
      .vld   (out_valid)
   );
endmodule

// File: tb/tb_typed_rr_arbiter.sv
// tb_typed_rr_arbiter: directed and random checks of typed_rr_arbiter against a behavioural model
import typed_arb_pkg::*;

module tb_typed_rr_arbiter;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [3:0] req_valid = '0, req_ready;
   three_t req_data [4];
   logic out_valid, out_ready = 1'b0, busy;
   three_t out_data;
   logic [1:0] out_id;
   logic [3:0] s_req_valid = '0, s_req_ready;
   shortint s_req_data [4];
   logic s_out_valid, s_out_ready = 1'b0, s_busy;
   shortint s_out_data;
   logic [1:0] s_out_id;
   int errors = 0, checks = 0;
   int m_ptr = 0, m_id = 0;
   bit m_full = 0;
   three_t m_data = '0;
   logic [31:0] sd, si;

   always #5 clk = ~clk;

   typed_rr_arbiter #(.p_t(three_t), .NREQ(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
      .out_id(out_id), .out_ready(out_ready), .busy(busy)
   );

   typed_rr_arbiter #(.p_t(shortint), .NREQ(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_data(s_req_data),
      .req_ready(s_req_ready), .out_valid(s_out_valid), .out_data(s_out_data),
      .out_id(s_out_id), .out_ready(s_out_ready), .busy(s_busy)
   );

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   function automatic int m_grant();
      for (int i = 0; i < 4; i++)
         if (req_valid[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
      return -1;
   endfunction

   function automatic void m_reset();
      m_ptr = 0; m_id = 0; m_full = 0; m_data = '0;
   endfunction

   // called just after a negedge with inputs applied; returns at the next negedge
   task automatic cycle();
      int g;
      bit take;
      #1;
      g = m_grant();
      take = g >= 0 && (!m_full || out_ready);
      chk("req_ready", req_ready, take ? 4'b1 << g : 4'b0);
      chk("out_valid", out_valid, m_full);
      chk("out_data", out_data, m_data);
      chk("out_id", out_id, m_id);
      chk("busy", busy, m_full);
      @(posedge clk);
      if (take) begin
         m_full = 1; m_data = ~req_data[g]; m_id = g; m_ptr = (g + 1) % 4;
      end else if (out_ready) m_full = 0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         req_data[i] = '0;
         s_req_data[i] = '0;
      end
      req_valid = 4'hF;
      #1;
      chk("rst_ready", req_ready, 4'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 3'b0);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      do_reset();
      // single request
      req_valid = 4'b0010; req_data[1] = 3'b101; out_ready = 1'b1;
      #1 chk("single_ready", req_ready, 4'b0010);
      cycle();
      chk("single_valid", out_valid, 1'b1);
      chk("single_data", out_data, 3'b010);
      chk("single_id", out_id, 2'd1);
      req_valid = '0;
      cycle();
      chk("drain_valid", out_valid, 1'b0);
      do_reset();
      // continuous round robin
      req_valid = 4'hF;
      for (int n = 0; n < 8; n++) begin
         req_data[n % 4] = three_t'($urandom);
         #1 chk("rr_grant", req_ready, 4'b1 << (n % 4));
         cycle();
         chk("rr_valid", out_valid, 1'b1);
         chk("rr_id", out_id, n % 4);
      end
      req_valid = 4'b1001;
      #1 chk("wrap_g0", req_ready, 4'b0001);
      cycle();
      #1 chk("wrap_g3", req_ready, 4'b1000);
      cycle();
      // backpressure
      out_ready = 1'b0; req_valid = 4'hF;
      sd = 32'(out_data); si = 32'(out_id);
      repeat (5) begin
         #1 chk("bp_ready", req_ready, 4'b0);
         chk("bp_busy", busy, 1'b1);
         chk("bp_data", out_data, sd);
         chk("bp_id", out_id, si);
         cycle();
      end
      out_ready = 1'b1;
      #1 chk("bp_release", req_ready, 4'b0001);
      cycle();
      // asynchronous reset with a result held
      chk("pre_rst_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_data", out_data, 3'b0);
      chk("arst_id", out_id, 2'd0);
      chk("arst_ready", req_ready, 4'b0);
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("post_rst_g0", req_ready, 4'b0001);
      cycle();
      // full-width inversion on the shortint instance
      s_req_valid = 4'b0100; s_req_data[2] = 16'h00FF; s_out_ready = 1'b1;
      #1 chk("w_ready", s_req_ready, 4'b0100);
      @(posedge clk);
      @(negedge clk);
      s_req_valid = '0;
      chk("w_valid", s_out_valid, 1'b1);
      chk("w_data", 32'($unsigned(s_out_data)), 32'h0000FF00);
      chk("w_id", s_out_id, 2'd2);
      m_full = out_valid; m_data = out_data; m_id = out_id;
      // the main instance ran unchecked for one cycle; resync via reset
      do_reset();
      repeat (3000) begin
         req_valid = 4'($urandom);
         for (int i = 0; i < 4; i++) req_data[i] = three_t'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         cycle();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
